// File: rtl/ocimem_pkg.sv
// rtl/ocimem_pkg.sv - shared types and jdo field map for the debug on-chip memory
package ocimem_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      JRD  = 3'd1,
      JWR  = 3'd2,
      CRD  = 3'd3,
      CWR  = 3'd4,
      DONE = 3'd5
   } ocimem_state_t;

   localparam int ADDR_LSB = 26;
   localparam int RDFLAG   = 34;
   localparam int DATA_LSB = 3;

   localparam logic [7:0] PROT_BASE_DEF = 8'hF0;

endpackage

// File: rtl/chenillard_sys_nios2_debug_ocimem_if.sv
// rtl/chenillard_sys_nios2_debug_ocimem_if.sv - CPU-side Avalon-MM slave bundle
interface chenillard_sys_nios2_debug_ocimem_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [3:0]        avs_byteenable;
   logic              avs_debugaccess;
   logic [31:0]       avs_readdata;
   logic              avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
      input  avs_readdata, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
      output avs_readdata, avs_waitrequest
   );
endinterface

// File: rtl/ocimem_ram.sv
// rtl/ocimem_ram.sv - single-port synchronous RAM, byte-lane writes, 1-cycle read latency
module ocimem_ram #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // Read returns the word as it was before a same-cycle write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/chenillard_sys_nios2_debug_ocimem.sv
// rtl/chenillard_sys_nios2_debug_ocimem.sv - debug RAM shared by JTAG monitor and CPU
module chenillard_sys_nios2_debug_ocimem
   import ocimem_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(PROT_BASE_DEF)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_no_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   chenillard_sys_nios2_debug_ocimem_if.slave avs,
   output logic [31:0] MonDReg,
   output logic        monitor_ready,
   output logic        monitor_error
);
   ocimem_state_t     state, state_nxt;
   logic [ADDR_W-1:0] MonAReg;

   logic              pend_valid, pend_wr;
   logic [ADDR_W-1:0] pend_addr;
   logic [31:0]       pend_data;

   logic              cur_cpu, cur_dbg;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_data;
   logic [3:0]        cur_be;

   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_data;
   logic [3:0]        sel_be;
   logic              sel_cpu, sel_dbg;

   logic [31:0]       readdata_q, ram_q;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [3:0]        ram_be;

   logic              j_any, j_op, j_wr, j_drop, cpu_req;
   logic [ADDR_W-1:0] j_base, j_next;
   logic [31:0]       j_data;
   logic              unused_jdo;

   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

   // Address load happens first, so a+b together writes at the freshly loaded address.
   assign j_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign j_base = take_action_ocimem_a ? jdo[ADDR_LSB +: ADDR_W] : MonAReg;
   assign j_data = jdo[DATA_LSB +: 32];
   assign j_wr   = take_action_ocimem_b;
   assign j_op   = take_action_ocimem_b |
                   (take_action_ocimem_a ? jdo[RDFLAG] : take_no_action_ocimem_a);
   assign j_next = (take_action_ocimem_b | (take_no_action_ocimem_a & ~take_action_ocimem_a))
                   ? j_base + ADDR_W'(1) : j_base;
   assign j_drop = j_op & pend_valid & (state != IDLE);

   assign cpu_req = avs.avs_read | avs.avs_write;

   always_comb begin
      state_nxt = state;
      sel_addr  = cur_addr;
      sel_data  = cur_data;
      sel_be    = 4'hF;
      sel_cpu   = 1'b0;
      sel_dbg   = 1'b1;
      case (state)
         IDLE: begin
            if (pend_valid) begin
               state_nxt = pend_wr ? JWR : JRD;
               sel_addr  = pend_addr;
               sel_data  = pend_data;
            end else if (j_op) begin
               state_nxt = j_wr ? JWR : JRD;
               sel_addr  = j_base;
               sel_data  = j_data;
            end else if (cpu_req) begin
               state_nxt = avs.avs_write ? CWR : CRD;
               sel_addr  = avs.avs_address;
               sel_data  = avs.avs_writedata;
               sel_be    = avs.avs_byteenable;
               sel_cpu   = 1'b1;
               sel_dbg   = avs.avs_debugaccess;
            end
         end
         JRD, JWR, CRD, CWR: state_nxt = DONE;
         default:            state_nxt = IDLE;
      endcase
   end

   // Reads are issued from IDLE so data is ready by the end of JRD/CRD.
   assign ram_addr = (state == IDLE) ? sel_addr : cur_addr;
   assign ram_we   = ((state == JWR) && (cur_addr < PROT_BASE)) || ((state == CWR) && cur_dbg);
   assign ram_be   = (state == CWR) ? cur_be : 4'hF;

   ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .be    (ram_be),
      .wdata (cur_data),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         MonAReg       <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
         readdata_q    <= '0;
         pend_valid    <= 1'b0;
         pend_wr       <= 1'b0;
         pend_addr     <= '0;
         pend_data     <= '0;
         cur_addr      <= '0;
         cur_data      <= '0;
         cur_be        <= '0;
         cur_cpu       <= 1'b0;
         cur_dbg       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            cur_addr <= sel_addr;
            cur_data <= sel_data;
            cur_be   <= sel_be;
            cur_cpu  <= sel_cpu;
            cur_dbg  <= sel_dbg;
         end
         if ((state == IDLE) && pend_valid) pend_valid <= 1'b0;
         if (j_op && !j_drop && ((state != IDLE) || pend_valid)) begin
            pend_valid <= 1'b1;
            pend_wr    <= j_wr;
            pend_addr  <= j_base;
            pend_data  <= j_data;
         end
         if (j_any && !j_drop) MonAReg <= j_next;
         if (state == JRD) MonDReg <= ram_q;
         if ((state == JRD) || (state == JWR)) monitor_ready <= 1'b1;
         if (j_any) monitor_ready <= 1'b0;
         if (take_action_ocimem_a) monitor_error <= 1'b0;
         if (j_drop || ((state == JWR) && (cur_addr >= PROT_BASE))) monitor_error <= 1'b1;
         if (state == CRD) readdata_q <= cur_dbg ? ram_q : '0;
      end
   end

   assign avs.avs_readdata    = readdata_q;
   assign avs.avs_waitrequest = cpu_req & ~((state == DONE) & cur_cpu) & ~reset;
endmodule
